// File: rtl/alu_pipe_ctrl.sv
// Handshaked WIDTH-bit ALU with registered result, status flags and a
// multi-cycle shift-add multiply.
//   clk, rst (sync, active-high)
//   in_valid/in_ready + op1, op2, sel : operation request
//   out_valid/out_ready + out, co, zero, neg, ovf : registered result
module alu_pipe_ctrl #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] op1,
  input  logic [WIDTH-1:0] op2,
  input  logic [2:0]       sel,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out,
  output logic             co,
  output logic             zero,
  output logic             neg,
  output logic             ovf
);

  typedef enum logic [1:0] {
    IDLE,
    EXEC,
    DONE
  } state_t;

  localparam logic [2:0] OP_MUL = 3'b101;
  // cnt counts completed shift-add steps; one extra EXEC cycle
  // at cnt==WIDTH writes the product out.
  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH);

  state_t               state;
  logic [2*WIDTH-1:0]   acc;
  logic [2*WIDTH-1:0]   mcand;
  logic [WIDTH-1:0]     mplier;
  logic [CNT_W-1:0]     cnt;

  logic                 accept;
  logic [WIDTH:0]       sum;
  logic [WIDTH-1:0]     res;
  logic                 res_co;
  logic                 res_ovf;
  logic [WIDTH-1:0]     mres;

  // DONE passes out_ready through so consume+accept has no bubble
  assign in_ready = (state == IDLE) ||
                    ((state == DONE) && out_ready);
  assign accept   = in_valid && in_ready;
  assign sum      = {1'b0, op1} + {1'b0, op2};
  assign mres     = acc[WIDTH-1:0];

  always_comb begin
    res     = op1;
    res_co  = 1'b0;
    res_ovf = 1'b0;
    case (sel)
      3'b000: begin
        res     = sum[WIDTH-1:0];
        res_co  = sum[WIDTH];
        res_ovf = (op1[WIDTH-1] == op2[WIDTH-1]) &&
                  (sum[WIDTH-1] != op1[WIDTH-1]);
      end
      3'b001: begin
        res    = {op1[WIDTH-2:0], 1'b0};
        res_co = op1[WIDTH-1];
      end
      3'b010: res = ~(op1 ^ op2);
      3'b011: begin
        res    = {1'b0, op1[WIDTH-1:1]};
        res_co = op1[0];
      end
      3'b110: res = ~op1 + WIDTH'(1);
      default: res = op1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      out       <= '0;
      co        <= 1'b0;
      zero      <= 1'b0;
      neg       <= 1'b0;
      ovf       <= 1'b0;
      out_valid <= 1'b0;
      acc       <= '0;
      mcand     <= '0;
      mplier    <= '0;
      cnt       <= '0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (accept) begin
            if (sel == OP_MUL) begin
              state     <= EXEC;
              out_valid <= 1'b0;
              acc       <= '0;
              cnt       <= '0;
              mcand     <= {{WIDTH{1'b0}}, op1};
              mplier    <= op2;
            end else begin
              state     <= DONE;
              out_valid <= 1'b1;
              out       <= res;
              co        <= res_co;
              zero      <= (res == '0);
              neg       <= res[WIDTH-1];
              ovf       <= res_ovf;
            end
          end else if (state == DONE && out_ready) begin
            state     <= IDLE;
            out_valid <= 1'b0;
          end
        end
        EXEC: begin
          if (cnt == LAST) begin
            state     <= DONE;
            out_valid <= 1'b1;
            out       <= mres;
            co        <= |acc[2*WIDTH-1:WIDTH];
            zero      <= (mres == '0);
            neg       <= mres[WIDTH-1];
            ovf       <= 1'b0;
          end else begin
            if (mplier[0]) acc <= acc + mcand;
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
            cnt    <= cnt + CNT_W'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_pipe_ctrl.sv
// Scoreboard bench for alu_pipe_ctrl at WIDTH=8.
// Expected {ovf,neg,zero,co,out} queued on accept, checked on consume.
module tb_alu_pipe_ctrl;

  logic       clk = 0;
  logic       rst = 1;
  logic       in_valid = 0;
  logic       in_ready;
  logic [7:0] op1 = 0;
  logic [7:0] op2 = 0;
  logic [2:0] sel = 0;
  logic       out_valid;
  logic       out_ready = 1;
  logic [7:0] out;
  logic       co, zero, neg, ovf;

  int nvec = 0;
  int nbad = 0;
  logic [11:0] q[$];

  alu_pipe_ctrl #(.WIDTH(8), .CNT_W(4)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .op1(op1), .op2(op2), .sel(sel),
    .out_valid(out_valid), .out_ready(out_ready),
    .out(out), .co(co), .zero(zero), .neg(neg), .ovf(ovf)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    nvec++;
    if (got !== exp) begin
      nbad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [11:0] model(input logic [2:0] s,
                                        input logic [7:0] a,
                                        input logic [7:0] b);
    logic [8:0]  w;
    logic [15:0] p;
    logic [7:0]  r;
    logic        c, v;
    int          sa;
    r = a; c = 0; v = 0;
    case (s)
      3'd0: begin
        w  = 9'(a) + 9'(b);
        r  = w[7:0];
        c  = w[8];
        sa = int'($signed(a)) + int'($signed(b));
        v  = (sa > 127) || (sa < -128);
      end
      3'd1: begin r = 8'(a * 2); c = a[7]; end
      3'd2: r = ~(a ^ b);
      3'd3: begin r = a / 2; c = a[0]; end
      3'd5: begin
        p = 16'(a) * 16'(b);
        r = p[7:0];
        c = (p[15:8] != 0);
      end
      3'd6: r = 8'(0 - a);
      default: r = a;
    endcase
    return {v, r[7], r == 8'd0, c, r};
  endfunction

  // result checker: compares on every consume
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      if (q.size() == 0) chk("res_unexp", 1, 0);
      else chk("res", {20'd0, ovf, neg, zero, co, out}, {20'd0, q.pop_front()});
    end
  end

  task automatic send(input logic [2:0] s,
                      input logic [7:0] a,
                      input logic [7:0] b);
    int   n = 0;
    logic ok = 0;
    sel = s; op1 = a; op2 = b; in_valid = 1;
    while (!ok && n < 50) begin
      @(negedge clk);
      ok = in_ready;
      @(posedge clk);
      n++;
    end
    if (!ok) chk("accept_to", 0, 1);
    else q.push_back(model(s, a, b));
    #1 in_valid = 0;
  endtask

  task automatic wait_valid(input string tag, input int exp);
    int k = 0;
    while (!out_valid && k < 30) begin
      @(posedge clk); #1;
      k++;
    end
    chk(tag, k, exp);
  endtask

  logic [2:0] s_ops[3] = '{3'd2, 3'd6, 3'd4};
  logic [7:0] s_a[3]   = '{8'hF0, 8'h01, 8'h5A};
  logic [7:0] s_b[3]   = '{8'h0F, 8'h00, 8'h00};

  initial begin
    #100000;
    $display("FAIL global_timeout got=1 exp=0");
    $fatal(1, "timeout");
  end

  initial begin
    repeat (2) @(posedge clk);
    #1;
    chk("rst_vld", out_valid, 0);
    chk("rst_out", out, 0);
    chk("rst_flg", {co, zero, neg, ovf}, 0);
    rst = 0;
    @(posedge clk); #1;
    chk("rst_rdy", in_ready, 1);

    // overflow/carry corners
    send(3'd0, 8'hFF, 8'h01);
    chk("t1_vld", out_valid, 1);
    chk("t1_zero", zero, 1);
    @(posedge clk); #1;
    chk("t1_drop", out_valid, 0);
    send(3'd0, 8'h7F, 8'h01);
    chk("t2_ovf", ovf, 1);
    send(3'd1, 8'h81, 8'h00);
    send(3'd3, 8'h03, 8'h00);

    // multiply latency
    send(3'd5, 8'h10, 8'h20);
    chk("mul_busy", in_ready, 0);
    wait_valid("mul_lat1", 9);
    @(posedge clk); #1;
    send(3'd5, 8'h0D, 8'h0B);
    wait_valid("mul_lat2", 9);
    chk("mul_out", out, 8'h8F);
    @(posedge clk); #1;

    // backpressure hold then no-bubble handoff
    out_ready = 0;
    send(3'd0, 8'h12, 8'h34);
    repeat (5) begin
      @(posedge clk); #1;
      chk("hold_vld", out_valid, 1);
      chk("hold_out", out, 8'h46);
      chk("hold_rdy", in_ready, 0);
    end
    out_ready = 1;
    send(3'd0, 8'h01, 8'h02);
    chk("nobub_vld", out_valid, 1);
    chk("nobub_out", out, 8'h03);
    @(posedge clk); #1;

    // streaming one per cycle
    in_valid = 1;
    for (int i = 0; i < 3; i++) begin
      sel = s_ops[i]; op1 = s_a[i]; op2 = s_b[i];
      @(negedge clk);
      chk("s_rdy", in_ready, 1);
      q.push_back(model(s_ops[i], s_a[i], s_b[i]));
      @(posedge clk); #1;
      chk("s_vld", out_valid, 1);
    end
    in_valid = 0;
    @(posedge clk); #1;
    chk("s_end", out_valid, 0);

    // reset aborts a multiply in flight
    send(3'd5, 8'hFF, 8'hFF);
    repeat (3) @(posedge clk);
    #1;
    chk("abort_pre", out_valid, 0);
    rst = 1;
    @(posedge clk); #1;
    rst = 0;
    q.delete();
    chk("abort_vld", out_valid, 0);
    chk("abort_out", out, 0);
    chk("abort_rdy", in_ready, 1);
    send(3'd0, 8'h05, 8'h03);
    chk("post_out", out, 8'h08);
    repeat (3) @(posedge clk);
    #1;
    chk("drain", q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nbad);
    $finish;
  end

endmodule
